// File: rtl/mem_pkg.sv
// Shared load/store definitions for the data-memory path.
// Size codes are also used by the decoder and the load-extension stage.
package mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB = LB;
  localparam logic [2:0] SH = LH;
  localparam logic [2:0] SW = LW;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    ERR
  } memState_t;

endpackage

// File: rtl/data_mem_ctrl_store_align.sv
// Byte-enable, lane-replicated store data and alignment checks.
// Purely combinational; loads always enable all four lanes.
module store_align
  import mem_pkg::*;
(
  input  logic [2:0]  dataSrc,
  input  logic        isStore,
  input  logic [31:0] writeData,
  input  logic [1:0]  offset,
  output logic [3:0]  byteEn,
  output logic [31:0] storeData,
  output logic        misaligned,
  output logic        illegal
);

  logic isByte;
  logic isHalf;
  logic isWord;

  // Size decode, lane steering and alignment
  always_comb begin
    isByte    = 1'b0;
    isHalf    = 1'b0;
    isWord    = 1'b0;
    illegal   = 1'b0;
    byteEn    = 4'b0000;
    storeData = writeData;
    unique case (1'b1)
      dataSrc == LB:             isByte = 1'b1;
      dataSrc == LH:             isHalf = 1'b1;
      dataSrc == LW:             isWord = 1'b1;
      dataSrc == LBU && !isStore: isByte = 1'b1;
      dataSrc == LHU && !isStore: isHalf = 1'b1;
      default:                   illegal = 1'b1;
    endcase
    misaligned = (isHalf & offset[0]) | (isWord & |offset);
    if (isByte) begin
      byteEn    = 4'b0001 << offset;
      storeData = {4{writeData[7:0]}};
    end
    if (isHalf) begin
      byteEn    = 4'b0011 << offset;
      storeData = {2{writeData[15:0]}};
    end
    if (isWord) begin
      byteEn    = 4'b1111;
      storeData = writeData;
    end
    if (!isStore) byteEn = 4'b1111;
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller: handshake to data memory with timeout,
// stalls the core while an access is in flight.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  DataSrc,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MemFault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  memState_t     state;
  memState_t     stateNext;
  logic [CW-1:0] waitCnt;
  logic [1:0]    offsetQ;
  logic          loadQ;
  logic [3:0]    beNext;
  logic [31:0]   wdataNext;
  logic          misaligned;
  logic          illegal;
  logic          anyReq;
  logic          badReq;
  logic          timeoutHit;

  assign anyReq     = MemRead | MemWrite;
  assign badReq     = (MemRead & MemWrite) | misaligned | illegal;
  assign timeoutHit = (waitCnt == CW'(TIMEOUT_CYCLES - 1)) & ~mem_ready;

  store_align uAlign (
    .dataSrc   (DataSrc),
    .isStore   (MemWrite),
    .writeData (WriteData),
    .offset    (ALUResult[1:0]),
    .byteEn    (beNext),
    .storeData (wdataNext),
    .misaligned(misaligned),
    .illegal   (illegal)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Next state, stall and fault outputs
  always_comb begin
    stateNext = state;
    Stall     = 1'b0;
    MemFault  = 1'b0;
    unique case (state)
      IDLE: begin
        if (anyReq) begin
          Stall     = reset_n;
          stateNext = badReq ? ERR : BUSY;
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (mem_ready)       stateNext = DONE;
        else if (timeoutHit) stateNext = ERR;
      end
      DONE: stateNext = IDLE;
      ERR: begin
        MemFault  = 1'b1;
        stateNext = IDLE;
      end
    endcase
  end

  // Bus registers, wait counter and load result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ReadData  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      waitCnt   <= '0;
      offsetQ   <= '0;
      loadQ     <= 1'b0;
    end else begin
      if (state == IDLE && anyReq && !badReq) begin
        mem_req   <= 1'b1;
        mem_we    <= MemWrite;
        mem_addr  <= {ALUResult[31:2], 2'b00};
        mem_be    <= beNext;
        mem_wdata <= wdataNext;
        offsetQ   <= ALUResult[1:0];
        loadQ     <= MemRead;
      end
      if (state == BUSY) begin
        if (mem_ready) begin
          mem_req <= 1'b0;
          waitCnt <= '0;
          if (loadQ) ReadData <= mem_rdata >> {offsetQ, 3'b000};
        end else if (timeoutHit) begin
          mem_req  <= 1'b0;
          waitCnt  <= '0;
          ReadData <= '0;
        end else begin
          waitCnt <= waitCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Load/store controller sitting between the core's ALU/register-file outputs and a handshaked data-memory port; its aligned `ReadData` output feeds the load sign/zero-extension stage directly. Per access it checks alignment, generates byte enables and lane-replicated store data, runs a request/ready handshake with a bounded-latency timeout, and right-justifies the loaded word by byte offset. While an access is in flight it holds the single-cycle core with `Stall`.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles `mem_req` is held without `mem_ready` before the access is aborted.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `ALUResult` input 32: byte address of the access.
- `WriteData` input 32: store data, right-justified.
- `MemRead` input 1: load request.
- `MemWrite` input 1: store request. `MemRead` and `MemWrite` both high is treated as a fault.
- `DataSrc` input 3: size code. Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000 sb, 001 sh, 010 sw. All other codes are illegal.
- `ReadData` output 32: loaded word shifted right by 8×byte offset, so the addressed byte or half sits at bit 0.
- `Stall` output 1: freezes PC and register-file writeback.
- `MemFault` output 1: one-cycle pulse on misalignment, illegal code, or timeout.
- `mem_req` output 1: bus request, registered.
- `mem_we` output 1: write strobe, registered.
- `mem_addr` output 32: word-aligned address ({ALUResult[31:2], 2'b00}), registered.
- `mem_be` output 4: byte enables, registered. Forced to 4'b1111 on loads.
- `mem_wdata` output 32: lane-replicated store data, registered.
- `mem_ready` input 1: memory accepts the write, or returns `mem_rdata`, this cycle.
- `mem_rdata` input 32: read data, valid when `mem_ready` is high.

## Operation
- FSM states: IDLE, BUSY, DONE, ERR.
- IDLE:
  - No access (`MemRead`=`MemWrite`=0): stay in IDLE, `Stall`=0.
  - Legal access: latch address, `be`, `wdata`, `we`, and the 2-bit offset; `Stall`=1 combinationally; go to BUSY.
  - Illegal access (misaligned, illegal code, or both requests high): `Stall`=1; go to ERR. No bus activity.
- Misaligned definitions:
  - lh/lhu/sh with `ALUResult[0]`=1.
  - lw/sw with `ALUResult[1:0]`≠0.
- Byte enables and store data:
  - sb: `be`=4'b0001<<off, `wdata`={4{WriteData[7:0]}}.
  - sh: `be`=4'b0011<<off, `wdata`={2{WriteData[15:0]}}.
  - sw: `be`=4'b1111, `wdata`=WriteData.
- BUSY:
  - `mem_req`=1, `Stall`=1.
  - Timeout counter increments each cycle.
  - `mem_ready`=1: capture `mem_rdata`>>(8·off) into `ReadData` (loads only; stores leave it unchanged), clear the counter, go to DONE.
  - Counter reaches `TIMEOUT_CYCLES` without `mem_ready`: drop `mem_req`, set `ReadData`=0, go to ERR.
- DONE: `Stall`=0 for exactly one cycle so the core commits and advances; always go to IDLE.
- ERR: `MemFault`=1, `Stall`=0 for one cycle; go to IDLE.
- `mem_ready` outside BUSY is ignored.
- Request inputs are sampled only in IDLE; changes during BUSY are ignored.

## Timing
- Reset (asynchronous, while `reset_n`=0):
  - State=IDLE.
  - `ReadData`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0.
  - `MemFault`=0, counter=0.
  - `Stall`=0.
- Reset mid-BUSY: `mem_req` drops immediately; the access is abandoned with no fault pulse.
- Latency:
  - Access at edge N enters BUSY, so `mem_req` is high from N+1.
  - `mem_ready` at cycle M means `ReadData` is valid and `Stall`=0 in cycle M+1 (DONE).
  - Minimum total with zero-wait memory: 2 stalled cycles plus the DONE cycle.
- Handshake: `mem_req`, `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` stay stable from BUSY entry until the cycle after `mem_ready` or timeout.
- Timeout: the access aborts in the `TIMEOUT_CYCLES`-th BUSY cycle that has no `mem_ready`. `mem_ready` arriving in that same cycle wins; it is a normal completion.
- `ReadData` holds its value until the next completed load or a timeout.

## Structure
- Shared package `mem_pkg`:
  - `DataSrc` code constants (LB, LH, LW, LBU, LHU), shared with the extension stage and the main decoder.
  - FSM state enum.
- One natural sub-module, `store_align`: combinational `be`/`wdata`/misalign generation from `DataSrc`, `WriteData` and offset. Alignment stays in its own sub-module; the FSM, counter and output registers are in the top.

## Test plan
- lw at 0x100, memory returns 0xDEADBEEF after 3 wait cycles → `mem_addr`=0x100, `mem_be`=4'hF; `Stall` high for 5 cycles; `ReadData`=0xDEADBEEF in DONE.
- lb at 0x103, `mem_rdata`=0x80112233, zero wait → `ReadData`=0x00000080 (extension stage yields 0xFFFFFF80).
- sh at 0x202 with `WriteData`=0x0000ABCD → `mem_addr`=0x200, `mem_be`=4'b1100, `mem_wdata`=0xABCDABCD, `mem_we`=1; `MemFault` never asserted.
- lw at 0x101, then `DataSrc`=3'b111 load → each gives a one-cycle `MemFault`; `mem_req` never rises.
- `TIMEOUT_CYCLES`=4, `mem_ready` tied low → `mem_req` high for 4 cycles, then `MemFault` pulses, `ReadData`=0, FSM back in IDLE.
- `reset_n` pulled low in the 2nd BUSY cycle → `mem_req` and `Stall` drop without waiting for a clock edge; after release, a new lw completes normally.
